// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_pkg                                                         |
// | Brief    : ALUOp encoding, MDU state enumeration and op-class helpers.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package alu_pkg;

  localparam logic [3:0] c_OP_ADD   = 4'b0000;
  localparam logic [3:0] c_OP_SUB   = 4'b0001;
  localparam logic [3:0] c_OP_AND   = 4'b0010;
  localparam logic [3:0] c_OP_OR    = 4'b0011;
  localparam logic [3:0] c_OP_XOR   = 4'b0100;
  localparam logic [3:0] c_OP_SRL   = 4'b0101;
  localparam logic [3:0] c_OP_SRA   = 4'b0110;
  localparam logic [3:0] c_OP_SLL   = 4'b0111;
  localparam logic [3:0] c_OP_SLT   = 4'b1000;
  localparam logic [3:0] c_OP_SLTU  = 4'b1001;
  // With start=1 these two encodings become MTHI / MTLO.
  localparam logic [3:0] c_OP_MFHI  = 4'b1010;
  localparam logic [3:0] c_OP_MFLO  = 4'b1011;
  localparam logic [3:0] c_OP_MULT  = 4'b1100;
  localparam logic [3:0] c_OP_MULTU = 4'b1101;
  localparam logic [3:0] c_OP_DIV   = 4'b1110;
  localparam logic [3:0] c_OP_DIVU  = 4'b1111;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic is_seq_op(input logic [3:0] op);
    return op[3:2] == 2'b11;
  endfunction

  function automatic logic is_mt_op(input logic [3:0] op);
    return (op == c_OP_MFHI) || (op == c_OP_MFLO);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mdu                                                             |
// | Brief    : Multi-cycle multiply/divide unit with HI/LO and start/busy.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module mdu
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_op,
  input  logic             i_start,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int c_MAXLAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int c_CNTW   = (c_MAXLAT > 1) ? $clog2(c_MAXLAT) : 1;
  localparam logic [c_CNTW-1:0] c_MUL_LOAD = c_CNTW'(MUL_LAT - 1);
  localparam logic [c_CNTW-1:0] c_DIV_LOAD = c_CNTW'(DIV_LAT - 1);
  localparam logic [WIDTH-1:0]  c_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]  c_ONE      = WIDTH'(1);

  state_t                 r_state;
  state_t                 w_state_nx;
  logic [c_CNTW-1:0]      r_cnt;
  logic [c_CNTW-1:0]      w_cnt_nx;
  logic [2*WIDTH-1:0]     r_res;
  logic [2*WIDTH-1:0]     w_res_nx;
  logic [WIDTH-1:0]       r_hi;
  logic [WIDTH-1:0]       w_hi_nx;
  logic [WIDTH-1:0]       r_lo;
  logic [WIDTH-1:0]       w_lo_nx;

  logic                   w_done;
  logic                   w_seq_go;
  logic                   w_mt_go;
  logic [2*WIDTH-1:0]     w_prod_s;
  logic [2*WIDTH-1:0]     w_prod_u;
  logic                   w_b_zero;
  logic                   w_sovf;
  logic [WIDTH-1:0]       w_sden;
  logic [WIDTH-1:0]       w_uden;
  logic signed [WIDTH-1:0] w_sq;
  logic signed [WIDTH-1:0] w_sr;
  logic [WIDTH-1:0]       w_uq;
  logic [WIDTH-1:0]       w_ur;
  logic [2*WIDTH-1:0]     w_result;

  // The last busy cycle also accepts a new op, so issue is back-to-back.
  assign w_done   = (r_state == BUSY) && (r_cnt == '0);
  assign w_seq_go = i_start && ((r_state == IDLE) || w_done) && is_seq_op(i_op);
  assign w_mt_go  = i_start && (r_state == IDLE) && is_mt_op(i_op);

  assign w_prod_s = $signed({{WIDTH{i_a[WIDTH-1]}}, i_a}) *
                    $signed({{WIDTH{i_b[WIDTH-1]}}, i_b});
  assign w_prod_u = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};

  // Divisors are forced to 1 in the special cases so the divider never
  // sees a zero or overflowing operand; the special results are muxed in.
  assign w_b_zero = (i_b == '0);
  assign w_sovf   = (i_a == c_MOST_NEG) && (i_b == '1);
  assign w_sden   = (w_b_zero || w_sovf) ? c_ONE : i_b;
  assign w_uden   = w_b_zero ? c_ONE : i_b;
  assign w_sq     = $signed(i_a) / $signed(w_sden);
  assign w_sr     = $signed(i_a) % $signed(w_sden);
  assign w_uq     = i_a / w_uden;
  assign w_ur     = i_a % w_uden;

  always_comb begin
    w_result = '0;
    case (i_op)
      c_OP_MULT:  w_result = w_prod_s;
      c_OP_MULTU: w_result = w_prod_u;
      c_OP_DIV: begin
        if (w_b_zero)   w_result = {i_a, {WIDTH{1'b1}}};
        else if (w_sovf) w_result = {{WIDTH{1'b0}}, c_MOST_NEG};
        else            w_result = {w_sr, w_sq};
      end
      c_OP_DIVU: begin
        if (w_b_zero) w_result = {i_a, {WIDTH{1'b1}}};
        else          w_result = {w_ur, w_uq};
      end
      default:    w_result = '0;
    endcase
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_res_nx   = r_res;
    w_hi_nx    = r_hi;
    w_lo_nx    = r_lo;

    if (w_done) begin
      w_hi_nx    = r_res[2*WIDTH-1:WIDTH];
      w_lo_nx    = r_res[WIDTH-1:0];
      w_state_nx = IDLE;
    end else if (r_state == BUSY) begin
      w_cnt_nx = r_cnt - c_CNTW'(1);
    end

    if (w_seq_go) begin
      w_state_nx = BUSY;
      w_cnt_nx   = i_op[1] ? c_DIV_LOAD : c_MUL_LOAD;
      w_res_nx   = w_result;
    end

    if (w_mt_go) begin
      if (i_op == c_OP_MFHI) w_hi_nx = i_a;
      else                   w_lo_nx = i_a;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_res   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_res   <= w_res_nx;
      r_hi    <= w_hi_nx;
      r_lo    <= w_lo_nx;
    end
  end

  assign o_busy = (r_state == BUSY);
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule
`default_nettype wire

// File: rtl/alu_mdu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_mdu                                                         |
// | Brief    : EX-stage ALU: combinational datapath plus multiply/divide unit. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUOp,
  input  logic             start,
  output logic [WIDTH-1:0] C,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int c_SHW = $clog2(WIDTH);

  logic [c_SHW-1:0] w_shamt;
  logic             w_slt;
  logic             w_sltu;
  logic [WIDTH-1:0] w_c;

  assign w_shamt = B[c_SHW-1:0];
  assign w_slt   = $signed(A) < $signed(B);
  assign w_sltu  = A < B;

  always_comb begin
    w_c = '0;
    case (ALUOp)
      c_OP_ADD:  w_c = A + B;
      c_OP_SUB:  w_c = A - B;
      c_OP_AND:  w_c = A & B;
      c_OP_OR:   w_c = A | B;
      c_OP_XOR:  w_c = A ^ B;
      c_OP_SRL:  w_c = A >> w_shamt;
      c_OP_SRA:  w_c = $signed(A) >>> w_shamt;
      c_OP_SLL:  w_c = A << w_shamt;
      c_OP_SLT:  w_c = {{(WIDTH-1){1'b0}}, w_slt};
      c_OP_SLTU: w_c = {{(WIDTH-1){1'b0}}, w_sltu};
      c_OP_MFHI: w_c = hi;
      c_OP_MFLO: w_c = lo;
      default:   w_c = '0;
    endcase
  end

  assign C = w_c;

  mdu #(
    .WIDTH   (WIDTH),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_mdu (
    .clk     (clk),
    .rst     (reset),
    .i_a     (A),
    .i_b     (B),
    .i_op    (ALUOp),
    .i_start (start),
    .o_busy  (busy),
    .o_hi    (hi),
    .o_lo    (lo)
  );

endmodule
`default_nettype wire
